// File: rtl/nvme_pkg.sv
// Shared types, constants and helpers for the NVMe queue arbitration blocks.
// Latency: none; this package holds types and functions only.
// Backpressure: none.
package nvme_pkg;

  localparam int NUM_SQ_DEF = 4;
  localparam int PTR_W_DEF  = 8;
  localparam int QID_W_DEF  = $clog2(NUM_SQ_DEF);

  typedef logic [QID_W_DEF-1:0] qid_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  // Wrap an index that is known to be below 2*n back into 0..n-1 without a divider.
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/nvme_sq_arbiter_if.sv
// Bundle of config, doorbell, fetch and head-update signals of the SQ arbiter.
// Latency: none; wiring only.
// Backpressure: fetch_valid/fetch_ready handshake carried through unchanged.
interface nvme_sq_arbiter_if
  import nvme_pkg::*;
#(
  parameter int NUM_SQ = NUM_SQ_DEF,
  parameter int PTR_W  = PTR_W_DEF,
  parameter int QID_W  = $clog2(NUM_SQ)
);

  logic [NUM_SQ-1:0] cfg_en;
  logic [PTR_W-1:0]  cfg_qsize_m1;
  logic              db_wr_en;
  logic [QID_W-1:0]  db_qid;
  logic [PTR_W-1:0]  db_tail;
  logic              db_err;
  logic              fetch_valid;
  logic [QID_W-1:0]  fetch_qid;
  logic [PTR_W-1:0]  fetch_slot;
  logic              fetch_ready;
  logic              fetch_done;
  logic              head_upd_valid;
  logic [QID_W-1:0]  head_upd_qid;
  logic [PTR_W-1:0]  head_upd_head;
  logic              busy;

  // Arbiter side.
  modport slave (
    input  cfg_en, cfg_qsize_m1, db_wr_en, db_qid, db_tail, fetch_ready, fetch_done,
    output db_err, fetch_valid, fetch_qid, fetch_slot,
           head_upd_valid, head_upd_qid, head_upd_head, busy
  );

  // Host / fetch-engine side.
  modport master (
    output cfg_en, cfg_qsize_m1, db_wr_en, db_qid, db_tail, fetch_ready, fetch_done,
    input  db_err, fetch_valid, fetch_qid, fetch_slot,
           head_upd_valid, head_upd_qid, head_upd_head, busy
  );

endinterface

// File: rtl/nvme_rr_pick.sv
// Round-robin first-requester search starting at ptr_i, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
module nvme_rr_pick
  import nvme_pkg::*;
#(
  parameter int N     = NUM_SQ_DEF,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             vld_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] scan_idx;

  // Visit ptr_i, ptr_i+1, ... (mod N); the first asserted request wins.
  always_comb begin
    vld_o    = 1'b0;
    idx_o    = '0;
    scan_idx = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = IDX_W'(wrap_idx(int'(ptr_i) + i, N));
      if (!vld_o && req_i[scan_idx]) begin
        vld_o = 1'b1;
        idx_o = scan_idx;
      end
    end
  end

endmodule

// File: rtl/nvme_sq_arbiter.sv
// Round-robin share of one command-fetch path across NUM_SQ submission queues.
// Latency: doorbell to fetch_valid 2 cycles when idle; 3 cycles minimum per fetch.
// Backpressure: fetch held stable until fetch_ready; one fetch outstanding until fetch_done.
module nvme_sq_arbiter
  import nvme_pkg::*;
#(
  parameter int NUM_SQ = NUM_SQ_DEF,
  parameter int PTR_W  = PTR_W_DEF,
  parameter int QID_W  = $clog2(NUM_SQ)
) (
  input logic              clk,
  input logic              reset_n,
  nvme_sq_arbiter_if.slave sq
);

  arb_state_e       state_q, state_d;
  logic [QID_W-1:0] grant_qid_q, grant_qid_d;
  logic [PTR_W-1:0] slot_q, slot_d;
  logic [QID_W-1:0] rr_ptr_q, rr_ptr_d;
  // Set once the granted queue is seen disabled while its fetch is in flight.
  logic             aborted_q, aborted_d;

  logic [PTR_W-1:0] head_q [NUM_SQ];
  logic [PTR_W-1:0] tail_q [NUM_SQ];

  logic             db_err_q;
  logic             head_upd_valid_q;
  logic [QID_W-1:0] head_upd_qid_q;
  logic [PTR_W-1:0] head_upd_head_q;

  logic [NUM_SQ-1:0] pending;
  logic              pick_vld;
  logic [QID_W-1:0]  pick_qid;
  logic              db_in_range;
  logic              db_ok;
  logic              done_acc;
  logic              head_inc;
  logic [PTR_W-1:0]  head_next;

  // A queue has work when it is live and its head trails its tail.
  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_SQ; i++) begin
      pending[i] = sq.cfg_en[i] && (head_q[i] != tail_q[i]);
    end
  end

  nvme_rr_pick #(
    .N     (NUM_SQ),
    .IDX_W (QID_W)
  ) u_pick (
    .req_i (pending),
    .ptr_i (rr_ptr_q),
    .vld_o (pick_vld),
    .idx_o (pick_qid)
  );

  // Doorbell qualification; the range check matters only when NUM_SQ is not a power of two.
  assign db_in_range = int'(sq.db_qid) < NUM_SQ;
  assign db_ok       = sq.db_wr_en && db_in_range && sq.cfg_en[sq.db_qid] &&
                       (sq.db_tail <= sq.cfg_qsize_m1);

  // Head advance for the granted queue, wrapping at the configured depth.
  assign head_next = (head_q[grant_qid_q] == sq.cfg_qsize_m1) ? '0
                                                              : head_q[grant_qid_q] + 1'b1;
  assign head_inc  = done_acc && !aborted_q && sq.cfg_en[grant_qid_q];

  // Next-state logic: grant in IDLE, hold the request in ISSUE, await completion in WAIT.
  always_comb begin
    state_d     = state_q;
    grant_qid_d = grant_qid_q;
    slot_d      = slot_q;
    rr_ptr_d    = rr_ptr_q;
    aborted_d   = aborted_q;
    done_acc    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          grant_qid_d = pick_qid;
          slot_d      = head_q[pick_qid];
          aborted_d   = 1'b0;
          state_d     = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (!sq.cfg_en[grant_qid_q]) aborted_d = 1'b1;
        if (sq.fetch_ready)          state_d   = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (!sq.cfg_en[grant_qid_q]) aborted_d = 1'b1;
        if (sq.fetch_done) begin
          done_acc = 1'b1;
          rr_ptr_d = QID_W'(wrap_idx(int'(grant_qid_q) + 1, NUM_SQ));
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Arbitration state and latched grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      grant_qid_q <= '0;
      slot_q      <= '0;
      rr_ptr_q    <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_qid_q <= grant_qid_d;
      slot_q      <= slot_d;
      rr_ptr_q    <= rr_ptr_d;
      aborted_q   <= aborted_d;
    end
  end

  // Per-queue pointers: disabled queues are held at zero, otherwise doorbell and fetch act independently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SQ; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SQ; i++) begin
        if (!sq.cfg_en[i]) begin
          head_q[i] <= '0;
          tail_q[i] <= '0;
        end else begin
          if (head_inc && (int'(grant_qid_q) == i)) head_q[i] <= head_next;
          if (db_ok && (int'(sq.db_qid) == i))     tail_q[i] <= sq.db_tail;
        end
      end
    end
  end

  // Registered status pulses: doorbell rejection and head-advance report.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_err_q         <= 1'b0;
      head_upd_valid_q <= 1'b0;
      head_upd_qid_q   <= '0;
      head_upd_head_q  <= '0;
    end else begin
      db_err_q         <= sq.db_wr_en && !db_ok;
      head_upd_valid_q <= head_inc;
      if (head_inc) begin
        head_upd_qid_q  <= grant_qid_q;
        head_upd_head_q <= head_next;
      end
    end
  end

  assign sq.db_err         = db_err_q;
  assign sq.fetch_valid    = (state_q == ARB_ISSUE);
  assign sq.fetch_qid      = grant_qid_q;
  assign sq.fetch_slot     = slot_q;
  assign sq.head_upd_valid = head_upd_valid_q;
  assign sq.head_upd_qid   = head_upd_qid_q;
  assign sq.head_upd_head  = head_upd_head_q;
  assign sq.busy           = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_nvme_sq_arbiter.sv
// Directed bench for the SQ round-robin arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
// Fetch engine responses are driven explicitly by the step sequence.
module tb_nvme_sq_arbiter;

  localparam int NUM_SQ = 4;
  localparam int PTR_W  = 8;
  localparam int QID_W  = 2;

  logic  clk = 1'b0;
  logic  reset_n;
  int    tests = 0;
  int    fails = 0;
  string phase = "init";

  nvme_sq_arbiter_if #(.NUM_SQ(NUM_SQ), .PTR_W(PTR_W), .QID_W(QID_W)) sq ();

  nvme_sq_arbiter #(.NUM_SQ(NUM_SQ), .PTR_W(PTR_W), .QID_W(QID_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sq      (sq.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doorbell(input int qid, input int tail);
    sq.db_wr_en = 1'b1;
    sq.db_qid   = QID_W'(qid);
    sq.db_tail  = PTR_W'(tail);
    step();
    sq.db_wr_en = 1'b0;
  endtask

  task automatic chk_all_zero();
    chk("z_db_err",   sq.db_err, 0);
    chk("z_fvld",     sq.fetch_valid, 0);
    chk("z_fqid",     sq.fetch_qid, 0);
    chk("z_fslot",    sq.fetch_slot, 0);
    chk("z_uvld",     sq.head_upd_valid, 0);
    chk("z_uqid",     sq.head_upd_qid, 0);
    chk("z_uhead",    sq.head_upd_head, 0);
    chk("z_busy",     sq.busy, 0);
  endtask

  task automatic wait_valid(output int waited);
    waited = 0;
    while (!sq.fetch_valid && waited < 20) begin
      step();
      waited++;
    end
    chk("fetch_seen", sq.fetch_valid, 1);
  endtask

  // One complete fetch with immediate ready and done; ends in IDLE on a falling edge.
  task automatic do_fetch(input int qid, input int slot, input int new_head, output int waited);
    wait_valid(waited);
    if (!sq.fetch_valid) return;
    chk("fetch_qid",  sq.fetch_qid, qid);
    chk("fetch_slot", sq.fetch_slot, slot);
    chk("busy_issue", sq.busy, 1);
    sq.fetch_ready = 1'b1;
    step();
    sq.fetch_ready = 1'b0;
    chk("vld_drop",  sq.fetch_valid, 0);
    chk("busy_wait", sq.busy, 1);
    sq.fetch_done = 1'b1;
    step();
    sq.fetch_done = 1'b0;
    chk("upd_vld",   sq.head_upd_valid, 1);
    chk("upd_qid",   sq.head_upd_qid, qid);
    chk("upd_head",  sq.head_upd_head, new_head);
    chk("busy_idle", sq.busy, 0);
  endtask

  initial begin
    int w;
    reset_n         = 1'b0;
    sq.cfg_en       = '0;
    sq.cfg_qsize_m1 = '0;
    sq.db_wr_en     = 1'b0;
    sq.db_qid       = '0;
    sq.db_tail      = '0;
    sq.fetch_ready  = 1'b0;
    sq.fetch_done   = 1'b0;

    // Reset state
    phase = "reset";
    @(negedge clk);
    chk_all_zero();
    reset_n = 1'b1;

    // Single queue, three entries, doorbell-to-fetch latency
    phase = "t1";
    sq.cfg_qsize_m1 = 8'd7;
    sq.cfg_en       = 4'b0001;
    step();
    doorbell(0, 3);
    chk("db_ok_noerr", sq.db_err, 0);
    chk("lat_n1",      sq.fetch_valid, 0);
    step();
    chk("lat_n2",      sq.fetch_valid, 1);
    do_fetch(0, 0, 1, w);
    chk("first_wait", w, 0);
    do_fetch(0, 1, 2, w);
    chk("gap1", w, 1);
    do_fetch(0, 2, 3, w);
    chk("gap2", w, 1);
    step();
    chk("t1_upd_drop", sq.head_upd_valid, 0);
    chk("t1_idle_vld", sq.fetch_valid, 0);
    chk("t1_idle_busy", sq.busy, 0);

    // Four queues, two entries each, strict round-robin
    phase = "t2";
    reset_n = 1'b0;
    step();
    reset_n   = 1'b1;
    sq.cfg_en = 4'b1111;
    doorbell(0, 2);
    doorbell(1, 2);
    doorbell(2, 2);
    doorbell(3, 2);
    do_fetch(0, 0, 1, w);
    chk("t2_first", w, 0);
    for (int q = 1; q < 4; q++) begin
      do_fetch(q, 0, 1, w);
      chk("t2_gap_a", w, 1);
    end
    for (int q = 0; q < 4; q++) begin
      do_fetch(q, 1, 2, w);
      chk("t2_gap_b", w, 1);
    end
    step();
    chk("t2_drained", sq.fetch_valid, 0);

    // Head wrap on q2: bring head to 6, then tail 1 gives slots 6,7,0
    phase = "t3";
    doorbell(2, 6);
    for (int k = 0; k < 4; k++) do_fetch(2, 2 + k, 3 + k, w);
    doorbell(2, 1);
    do_fetch(2, 6, 7, w);
    do_fetch(2, 7, 0, w);
    do_fetch(2, 0, 1, w);

    // Rejected doorbells: tail beyond depth, then a disabled queue
    phase = "t4";
    doorbell(1, 9);
    chk("err_range", sq.db_err, 1);
    step();
    chk("err_range_drop", sq.db_err, 0);
    for (int k = 0; k < 3; k++) begin
      chk("range_nofetch", sq.fetch_valid, 0);
      step();
    end
    sq.cfg_en = 4'b1101;
    doorbell(1, 5);
    chk("err_dis", sq.db_err, 1);
    step();
    chk("err_dis_drop", sq.db_err, 0);
    sq.cfg_en = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      chk("dis_nofetch", sq.fetch_valid, 0);
      step();
    end

    // Backpressure hold, doorbell during ISSUE, disable during WAIT
    phase = "t5";
    doorbell(3, 3);
    wait_valid(w);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        sq.db_wr_en = 1'b1;
        sq.db_qid   = 2'd3;
        sq.db_tail  = 8'd4;
      end
      step();
      sq.db_wr_en = 1'b0;
      chk("hold_vld",  sq.fetch_valid, 1);
      chk("hold_qid",  sq.fetch_qid, 3);
      chk("hold_slot", sq.fetch_slot, 2);
    end
    sq.fetch_ready = 1'b1;
    step();
    sq.fetch_ready = 1'b0;
    chk("t5_wait_busy", sq.busy, 1);
    sq.cfg_en = 4'b0111;
    step();
    sq.fetch_done = 1'b1;
    step();
    sq.fetch_done = 1'b0;
    chk("t5_no_upd",  sq.head_upd_valid, 0);
    chk("t5_idle",    sq.busy, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_nofetch", sq.fetch_valid, 0);
    end

    // Reset during WAIT, late fetch_done ignored, next fetch starts at slot 0
    phase = "t6";
    sq.cfg_en = 4'b1111;
    doorbell(0, 3);
    wait_valid(w);
    chk("t6_slot", sq.fetch_slot, 2);
    sq.fetch_ready = 1'b1;
    step();
    sq.fetch_ready = 1'b0;
    chk("t6_in_wait", sq.busy, 1);
    reset_n = 1'b0;
    #1;
    chk_all_zero();
    step();
    chk_all_zero();
    reset_n = 1'b1;
    sq.fetch_done = 1'b1;
    step();
    sq.fetch_done = 1'b0;
    chk("t6_no_upd",  sq.head_upd_valid, 0);
    chk("t6_idle",    sq.busy, 0);
    step();
    chk("t6_nofetch", sq.fetch_valid, 0);
    doorbell(0, 1);
    do_fetch(0, 0, 1, w);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
